mem_access_ctrl: RTL and testbench

- Sits directly downstream of the MEM stage.
- Consumes MEM's ramOp/ramAddr/storeData, runs a multi-cycle access to the board's asynchronous 32-bit SRAM, and returns formatted load data to MEM's load_data_i.
- Holds the pipeline through stall_req_o until the access completes.

---
 rtl/mem_access_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-cycle access to an asynchronous 32-bit SRAM for the MEM stage.
// Ports: clk, rst (sync, active-low); ramOp_i/ramAddr_i/storeData_i from MEM;
//   load_data_o, stall_req_o back to the pipeline; sram_* drive the SRAM pins.
// Optional: define MEM_ACCESS_PERF_CNT_EN to add stall_cycles_o and access_cnt_o.
module mem_access_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        ramOp_i,
    input  logic [31:0]       ramAddr_i,
    input  logic [31:0]       storeData_i,
    output logic [31:0]       load_data_o,
    output logic              stall_req_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_data_o,
    input  logic [31:0]       sram_data_i,
    output logic              sram_data_oe_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic [3:0]        sram_be_n_o
`ifdef MEM_ACCESS_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles_o,
    output logic [31:0]       access_cnt_o
`endif
);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_q;
    logic [1:0]       alo_q;
    logic             is_load;
    logic             is_store;
    logic [31:0]      st_data;
    logic [3:0]       st_be_n;
    logic             enter_done;

    // Upper address bits lie outside the SRAM and are intentionally dropped.
    logic unused_addr;
    assign unused_addr = &{1'b0, ramAddr_i[31:ADDR_W+2]};

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        st_data  = storeData_i;
        st_be_n  = 4'h0;
        unique case (1'b1)
            (ramOp_i == OP_LB), (ramOp_i == OP_LBU),
            (ramOp_i == OP_LH), (ramOp_i == OP_LHU),
            (ramOp_i == OP_LW): is_load = 1'b1;
            (ramOp_i == OP_SW): is_store = 1'b1;
            (ramOp_i == OP_SH): begin
                is_store = 1'b1;
                st_data  = {2{storeData_i[15:0]}};
                st_be_n  = ramAddr_i[1] ? 4'b0011 : 4'b1100;
            end
            (ramOp_i == OP_SB): begin
                is_store = 1'b1;
                st_data  = {4{storeData_i[7:0]}};
                st_be_n  = ~(4'b0001 << ramAddr_i[1:0]);
            end
            default: ;
        endcase
    end

    function automatic logic [31:0] fmt_load(
        input logic [3:0]  op,
        input logic [1:0]  a,
        input logic [31:0] w
    );
        logic [15:0] h;
        logic [7:0]  b;
        h = a[1] ? w[31:16] : w[15:0];
        b = 8'(w >> {a, 3'b000});
        case (op)
            OP_LH:   fmt_load = {{16{h[15]}}, h};
            OP_LHU:  fmt_load = {16'h0, h};
            OP_LB:   fmt_load = {{24{b[7]}}, b};
            OP_LBU:  fmt_load = {24'h0, b};
            default: fmt_load = w;
        endcase
    endfunction

    // Stall is raised combinationally so MEM freezes in the issue cycle itself.
    assign stall_req_o = rst & ((state == READ) | (state == WRITE) |
                                ((state == IDLE) & (is_load | is_store)));

    assign enter_done = ((state == READ) | (state == WRITE)) & (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= '0;
            op_q           <= OP_NOP;
            alo_q          <= 2'b00;
            load_data_o    <= '0;
            sram_addr_o    <= '0;
            sram_data_o    <= '0;
            sram_data_oe_o <= 1'b0;
            sram_ce_n_o    <= 1'b1;
            sram_oe_n_o    <= 1'b1;
            sram_we_n_o    <= 1'b1;
            sram_be_n_o    <= 4'hF;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt   <= '0;
                    op_q  <= ramOp_i;
                    alo_q <= ramAddr_i[1:0];
                    if (is_load) begin
                        state       <= READ;
                        sram_addr_o <= ramAddr_i[ADDR_W+1:2];
                        sram_ce_n_o <= 1'b0;
                        sram_oe_n_o <= 1'b0;
                        sram_be_n_o <= 4'h0;
                    end else if (is_store) begin
                        state          <= WRITE;
                        sram_addr_o    <= ramAddr_i[ADDR_W+1:2];
                        sram_data_o    <= st_data;
                        sram_data_oe_o <= 1'b1;
                        sram_ce_n_o    <= 1'b0;
                        sram_we_n_o    <= 1'b0;
                        sram_be_n_o    <= st_be_n;
                    end
                end
                READ: begin
                    if (cnt == LAST) begin
                        state       <= DONE;
                        sram_ce_n_o <= 1'b1;
                        sram_oe_n_o <= 1'b1;
                        load_data_o <= fmt_load(op_q, alo_q, sram_data_i);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (cnt == LAST) begin
                        state       <= DONE;
                        sram_ce_n_o <= 1'b1;
                        sram_we_n_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // data_oe was held through DONE for write hold time.
                    state          <= IDLE;
                    sram_data_oe_o <= 1'b0;
                    sram_be_n_o    <= 4'hF;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ACCESS_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles_o <= '0;
            access_cnt_o   <= '0;
        end else begin
            if (stall_req_o) stall_cycles_o <= stall_cycles_o + 32'd1;
            if (enter_done)  access_cnt_o   <= access_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: table-driven bench with SRAM model and load scoreboard.
// Optional perf-counter checks run when MEM_ACCESS_PERF_CNT_EN is defined.
module tb_mem_access_ctrl;

    localparam int AW = 20;
    localparam int WC = 2;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] load;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    ramOp_i = OP_LW;
    logic [31:0]   ramAddr_i = 32'h10;
    logic [31:0]   storeData_i = 32'h0;
    logic [31:0]   load_data_o;
    logic          stall_req_o;
    logic [AW-1:0] sram_addr_o;
    logic [31:0]   sram_data_o;
    logic [31:0]   sram_data_i;
    logic          sram_data_oe_o;
    logic          sram_ce_n_o;
    logic          sram_oe_n_o;
    logic          sram_we_n_o;
    logic [3:0]    sram_be_n_o;
`ifdef MEM_ACCESS_PERF_CNT_EN
    logic [31:0]   stall_cycles_o;
    logic [31:0]   access_cnt_o;
`endif

    mem_access_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
        .clk            (clk),
        .rst            (rst),
        .ramOp_i        (ramOp_i),
        .ramAddr_i      (ramAddr_i),
        .storeData_i    (storeData_i),
        .load_data_o    (load_data_o),
        .stall_req_o    (stall_req_o),
        .sram_addr_o    (sram_addr_o),
        .sram_data_o    (sram_data_o),
        .sram_data_i    (sram_data_i),
        .sram_data_oe_o (sram_data_oe_o),
        .sram_ce_n_o    (sram_ce_n_o),
        .sram_oe_n_o    (sram_oe_n_o),
        .sram_we_n_o    (sram_we_n_o),
        .sram_be_n_o    (sram_be_n_o)
`ifdef MEM_ACCESS_PERF_CNT_EN
        ,
        .stall_cycles_o (stall_cycles_o),
        .access_cnt_o   (access_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];

    assign sram_data_i = (!sram_ce_n_o && !sram_oe_n_o) ?
                         mem[sram_addr_o[7:0]] : 32'h0;

    always @(negedge clk) begin
        if (!sram_ce_n_o && !sram_we_n_o)
            for (int b = 0; b < 4; b++)
                if (!sram_be_n_o[b])
                    mem[sram_addr_o[7:0]][b*8 +: 8] <= sram_data_o[b*8 +: 8];
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q [$];
    logic [31:0] last_load = 32'h0;
    vec_t tbl [16];
    vec_t b2b [3];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the DONE cycle.
    task automatic issue(input vec_t v, input bit from_done);
        int stalls;
        int strb;
        logic [3:0]    be;
        logic [AW-1:0] ad;
        logic [31:0]   wd;
        bit ld;
        ld = (v.op >= OP_LB) && (v.op <= OP_LW);
        ramOp_i     = v.op;
        ramAddr_i   = v.addr;
        storeData_i = v.data;
        if (ld) sb_q.push_back(v.load);
        if (from_done) begin
            #1 chk("done_no_stall", {31'b0, stall_req_o}, 32'd0);
            @(negedge clk);
        end
        #1 chk("issue_stall", {31'b0, stall_req_o}, 32'd1);
        stalls = 1;
        strb   = 0;
        be     = 4'hF;
        ad     = '0;
        wd     = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall_req_o) break;
            stalls++;
            if (!sram_ce_n_o && (ld ? (!sram_oe_n_o && sram_we_n_o)
                                    : (!sram_we_n_o && sram_oe_n_o))) begin
                strb++;
                be = sram_be_n_o;
                ad = sram_addr_o;
                wd = sram_data_o;
            end
        end
        chk("stall_cycles", stalls, 1 + WC);
        chk("strobe_cycles", strb, WC);
        chk("be_n", {28'b0, be}, {28'b0, v.be});
        chk("sram_addr", {12'b0, ad}, {12'b0, v.addr[AW+1:2]});
        chk("done_strobes", {29'b0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o},
            32'd7);
        chk("done_data_oe", {31'b0, sram_data_oe_o}, {31'b0, !ld});
        if (!ld) chk("wdata", wd, v.wdata);
        if (ld) last_load = sb_q.pop_front();
        chk("load_data", load_data_o, last_load);
    endtask

    task automatic idle();
        ramOp_i = OP_NOP;
        @(negedge clk);
        chk("idle_stall", {31'b0, stall_req_o}, 32'd0);
        chk("idle_ce_n", {31'b0, sram_ce_n_o}, 32'd1);
        chk("idle_data_oe", {31'b0, sram_data_oe_o}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;

        tbl[0]  = '{OP_SW,  32'h10, 32'hDEADBEEF, 4'h0,    32'hDEADBEEF, 32'h0};
        tbl[1]  = '{OP_SB,  32'h13, 32'h000000A5, 4'b0111, 32'hA5A5A5A5, 32'h0};
        tbl[2]  = '{OP_LW,  32'h10, 32'h0,        4'h0,    32'h0, 32'hA5ADBEEF};
        tbl[3]  = '{OP_SW,  32'h10, 32'h80FF7F01, 4'h0,    32'h80FF7F01, 32'h0};
        tbl[4]  = '{OP_LH,  32'h12, 32'h0,        4'h0,    32'h0, 32'hFFFF80FF};
        tbl[5]  = '{OP_LHU, 32'h12, 32'h0,        4'h0,    32'h0, 32'h000080FF};
        tbl[6]  = '{OP_LB,  32'h11, 32'h0,        4'h0,    32'h0, 32'h0000007F};
        tbl[7]  = '{OP_LB,  32'h13, 32'h0,        4'h0,    32'h0, 32'hFFFFFF80};
        tbl[8]  = '{OP_LBU, 32'h13, 32'h0,        4'h0,    32'h0, 32'h00000080};
        tbl[9]  = '{OP_SH,  32'h22, 32'h12345678, 4'b0011, 32'h56785678, 32'h0};
        tbl[10] = '{OP_LW,  32'h20, 32'h0,        4'h0,    32'h0, 32'h56780000};
        tbl[11] = '{OP_LB,  32'h10, 32'h0,        4'h0,    32'h0, 32'h00000001};
        tbl[12] = '{OP_LH,  32'h10, 32'h0,        4'h0,    32'h0, 32'h00007F01};
        tbl[13] = '{OP_SB,  32'h20, 32'h000000FF, 4'b1110, 32'hFFFFFFFF, 32'h0};
        tbl[14] = '{OP_LBU, 32'h20, 32'h0,        4'h0,    32'h0, 32'h000000FF};
        tbl[15] = '{OP_LB,  32'h20, 32'h0,        4'h0,    32'h0, 32'hFFFFFFFF};

        b2b[0] = '{OP_LW, 32'h20, 32'h0,        4'h0, 32'h0, 32'h567800FF};
        b2b[1] = '{OP_SW, 32'h24, 32'hCAFEF00D, 4'h0, 32'hCAFEF00D, 32'h0};
        b2b[2] = '{OP_LW, 32'h24, 32'h0,        4'h0, 32'h0, 32'hCAFEF00D};

        // Reset held with a load pending on the inputs.
        repeat (3) @(negedge clk);
        chk("rst_strobes", {29'b0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o},
            32'd7);
        chk("rst_be_n", {28'b0, sram_be_n_o}, 32'hF);
        chk("rst_stall", {31'b0, stall_req_o}, 32'd0);
        chk("rst_load", load_data_o, 32'h0);
        chk("rst_addr", {12'b0, sram_addr_o}, 32'h0);
        chk("rst_data_oe", {31'b0, sram_data_oe_o}, 32'd0);
        rst = 1'b1;
        ramOp_i = OP_NOP;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            issue(tbl[i], 1'b0);
            idle();
        end

        // Undefined opcode behaves like NOP.
        ramOp_i = 4'hF;
        #1 chk("undef_stall", {31'b0, stall_req_o}, 32'd0);
        @(negedge clk);
        chk("undef_ce_n", {31'b0, sram_ce_n_o}, 32'd1);
        chk("undef_stall2", {31'b0, stall_req_o}, 32'd0);
        ramOp_i = OP_NOP;
        @(negedge clk);

        // Back-to-back ops with no NOP gap.
        issue(b2b[0], 1'b0);
        issue(b2b[1], 1'b1);
        issue(b2b[2], 1'b1);
        idle();

        // Reset in the second READ cycle aborts the access.
        ramOp_i   = OP_LW;
        ramAddr_i = 32'h10;
        @(negedge clk);
        chk("mid_read_oe_n", {31'b0, sram_oe_n_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ramOp_i = OP_NOP;
        @(negedge clk);
        chk("abort_strobes", {29'b0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o},
            32'd7);
        chk("abort_be_n", {28'b0, sram_be_n_o}, 32'hF);
        chk("abort_stall", {31'b0, stall_req_o}, 32'd0);
        rst = 1'b1;
        last_load = 32'h0;
        @(negedge clk);
        chk("abort_load_cleared", load_data_o, 32'h0);
        issue('{OP_LW, 32'h10, 32'h0, 4'h0, 32'h0, 32'h80FF7F01}, 1'b0);
        idle();

`ifdef MEM_ACCESS_PERF_CNT_EN
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("perf_rst_stall", stall_cycles_o, 32'd0);
        chk("perf_rst_acc", access_cnt_o, 32'd0);
        rst = 1'b1;
        last_load = 32'h0;
        @(negedge clk);
        issue('{OP_LW, 32'h10, 32'h0, 4'h0, 32'h0, 32'h80FF7F01}, 1'b0);
        idle();
        issue('{OP_SW, 32'h28, 32'h11223344, 4'h0, 32'h11223344, 32'h0},
              1'b0);
        idle();
        issue('{OP_LW, 32'h28, 32'h0, 4'h0, 32'h0, 32'h11223344}, 1'b0);
        idle();
        chk("perf_access_cnt", access_cnt_o, 32'd3);
        chk("perf_stall_cycles", stall_cycles_o, 32'd9);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
